lifo_stack: RTL and testbench

- Hardware LIFO stack that responds to the CPU's push/pop stack interface.
- Two instances are used in the processor:
  - the operand stack, wired to the `stack_*_operations` ports;
  - the subroutine return-address stack, wired to the `stack_*_subroutines` ports.
- Accepts push/pop commands, stores words in a register array, returns the popped word registered with one-cycle latency, and reports full/empty plus sticky overflow/underflow error flags.

---
 rtl/lifo_stack.sv | 145 ++++++++++++++
 tb/tb_lifo_stack.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lifo_stack.sv
// lifo_stack: register-array LIFO with push/pop command qualification,
// registered popped word (latency 1), full/empty/count status and sticky
// overflow/underflow error flags. Memory contents are intentionally unreset.
module lifo_stack #(
  parameter int WIDTH_DATA = 16,
  parameter int DEPTH      = 16,
  parameter int SP_WIDTH   = 5,
  parameter int EDGE_MODE  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH_DATA-1:0] data_in,
  output logic [WIDTH_DATA-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic [SP_WIDTH-1:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clear_errors
);

  localparam int                AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SP_WIDTH-1:0] SP_ONE   = SP_WIDTH'(1);
  localparam logic [SP_WIDTH-1:0] DEPTH_SP = SP_WIDTH'(DEPTH);

  logic [WIDTH_DATA-1:0] mem [DEPTH];
  logic [SP_WIDTH-1:0]   sp_r;
  logic                  push_d;
  logic                  pop_d;
  logic                  do_push_s;
  logic                  do_pop_s;
  logic                  full_s;
  logic                  empty_s;
  logic [AW-1:0]         top_addr_s;
  logic [WIDTH_DATA-1:0] top_word_s;
  logic                  mem_we_s;
  logic [AW-1:0]         mem_waddr_s;

  assign full_s     = (sp_r == DEPTH_SP);
  assign empty_s    = (sp_r == {SP_WIDTH{1'b0}});
  assign top_addr_s = AW'(sp_r - SP_ONE);
  assign top_word_s = mem[top_addr_s];

  assign full  = full_s;
  assign empty = empty_s;
  assign count = sp_r;

  // Qualify requests: rising edge of the request level, or level itself.
  always_comb begin
    do_push_s = 1'b0;
    do_pop_s  = 1'b0;
    if (EDGE_MODE != 0) begin
      do_push_s = push & ~push_d;
      do_pop_s  = pop & ~pop_d;
    end else begin
      do_push_s = push;
      do_pop_s  = pop;
    end
  end

  // Decide whether and where the array is written this cycle.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = AW'(sp_r);
    case ({do_push_s, do_pop_s})
      2'b10: begin
        if (!full_s) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = AW'(sp_r);
        end else begin
          mem_we_s = 1'b0;
        end
      end
      2'b11: begin
        // Replace the top entry; an empty stack just passes data through.
        if (!empty_s) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = top_addr_s;
        end else begin
          mem_we_s = 1'b0;
        end
      end
      default: begin
        mem_we_s = 1'b0;
      end
    endcase
  end

  // Storage array write port (contents deliberately not reset).
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_waddr_s] <= data_in;
    end
  end

  // Stack pointer, popped word, error flags and request history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_r      <= {SP_WIDTH{1'b0}};
      data_out  <= {WIDTH_DATA{1'b0}};
      overflow  <= 1'b0;
      underflow <= 1'b0;
      push_d    <= 1'b0;
      pop_d     <= 1'b0;
    end else begin
      push_d <= push;
      pop_d  <= pop;
      // Clear first so that a new error in the same cycle wins.
      if (clear_errors) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      case ({do_push_s, do_pop_s})
        2'b10: begin
          if (!full_s) begin
            sp_r <= sp_r + SP_ONE;
          end else begin
            overflow <= 1'b1;
          end
        end
        2'b01: begin
          if (!empty_s) begin
            data_out <= top_word_s;
            sp_r     <= sp_r - SP_ONE;
          end else begin
            underflow <= 1'b1;
          end
        end
        2'b11: begin
          if (!empty_s) begin
            data_out <= top_word_s;
          end else begin
            data_out <= data_in;
          end
        end
        default: begin
          sp_r <= sp_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lifo_stack.sv
// Directed self-checking bench for lifo_stack (EDGE_MODE=1, DEPTH=16).
module tb_lifo_stack;

  logic        clk = 1'b0;
  logic        reset;
  logic        push;
  logic        pop;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        full;
  logic        empty;
  logic [4:0]  count;
  logic        overflow;
  logic        underflow;
  logic        clear_errors;

  int n_cmp = 0;
  int n_err = 0;

  lifo_stack #(
    .WIDTH_DATA(16),
    .DEPTH     (16),
    .SP_WIDTH  (5),
    .EDGE_MODE (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .pop         (pop),
    .data_in     (data_in),
    .data_out    (data_out),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .clear_errors(clear_errors)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] v);
    push    = 1'b1;
    data_in = v;
    cycle();
    push = 1'b0;
    cycle();
  endtask

  task automatic pop_word();
    pop = 1'b1;
    cycle();
    pop = 1'b0;
    cycle();
  endtask

  initial begin
    reset        = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    data_in      = 16'h0000;
    clear_errors = 1'b0;
    repeat (3) cycle();
    check("rst_count", count, 32'd0);
    check("rst_empty", empty, 32'd1);
    check("rst_full", full, 32'd0);
    check("rst_dout", data_out, 32'h0);
    check("rst_ovf", overflow, 32'd0);
    check("rst_unf", underflow, 32'd0);
    reset = 1'b1;
    cycle();

    // Basic LIFO ordering
    push_word(16'h0011);
    push_word(16'h0022);
    push_word(16'h0033);
    check("t1_count3", count, 32'd3);
    pop_word();
    check("t1_pop_33", data_out, 32'h0033);
    check("t1_count2", count, 32'd2);
    pop_word();
    check("t1_pop_22", data_out, 32'h0022);
    pop_word();
    check("t1_pop_11", data_out, 32'h0011);
    check("t1_count0", count, 32'd0);
    check("t1_empty", empty, 32'd1);
    check("t1_unf", underflow, 32'd0);

    // Held request performs exactly one operation
    push    = 1'b1;
    data_in = 16'h00AA;
    repeat (5) cycle();
    push = 1'b0;
    cycle();
    check("t2_count1", count, 32'd1);
    pop = 1'b1;
    repeat (4) cycle();
    pop = 1'b0;
    cycle();
    check("t2_pop_aa", data_out, 32'h00AA);
    check("t2_count0", count, 32'd0);
    check("t2_unf", underflow, 32'd0);

    // Fill, overflow, clear
    for (int i = 1; i <= 16; i++) push_word(16'(i));
    check("t3_full", full, 32'd1);
    check("t3_count16", count, 32'd16);
    check("t3_ovf_pre", overflow, 32'd0);
    push_word(16'h7777);
    check("t3_count_hold", count, 32'd16);
    check("t3_ovf", overflow, 32'd1);
    pop_word();
    check("t3_pop_16", data_out, 32'd16);
    check("t3_notfull", full, 32'd0);
    check("t3_count15", count, 32'd15);
    check("t3_ovf_sticky", overflow, 32'd1);
    clear_errors = 1'b1;
    cycle();
    clear_errors = 1'b0;
    check("t3_ovf_clr", overflow, 32'd0);
    for (int i = 0; i < 15; i++) pop_word();
    check("t3_last_pop", data_out, 32'd1);
    check("t3_drained", count, 32'd0);
    check("t3_unf_none", underflow, 32'd0);

    // Underflow; new error beats simultaneous clear
    pop_word();
    check("t4_unf", underflow, 32'd1);
    check("t4_dout_hold", data_out, 32'd1);
    check("t4_count0", count, 32'd0);
    clear_errors = 1'b1;
    pop          = 1'b1;
    cycle();
    clear_errors = 1'b0;
    pop          = 1'b0;
    cycle();
    check("t4_unf_wins", underflow, 32'd1);
    clear_errors = 1'b1;
    cycle();
    clear_errors = 1'b0;
    check("t4_unf_clr", underflow, 32'd0);

    // Simultaneous push and pop
    push_word(16'd5);
    push_word(16'd9);
    push    = 1'b1;
    pop     = 1'b1;
    data_in = 16'h0100;
    cycle();
    check("t5_swap_dout", data_out, 32'd9);
    check("t5_swap_count", count, 32'd2);
    push = 1'b0;
    pop  = 1'b0;
    cycle();
    pop_word();
    check("t5_pop_100", data_out, 32'h0100);
    pop_word();
    check("t5_pop_5", data_out, 32'd5);
    check("t5_empty", empty, 32'd1);
    push    = 1'b1;
    pop     = 1'b1;
    data_in = 16'h0042;
    cycle();
    check("t5_pass_dout", data_out, 32'h0042);
    check("t5_pass_count", count, 32'd0);
    check("t5_pass_unf", underflow, 32'd0);
    push = 1'b0;
    pop  = 1'b0;
    cycle();

    // Asynchronous reset mid-cycle
    pop_word();
    check("t6_unf_set", underflow, 32'd1);
    push_word(16'h0001);
    push_word(16'h0002);
    push_word(16'h0003);
    check("t6_count3", count, 32'd3);
    #3;
    reset = 1'b0;
    #1;
    check("t6_arst_count", count, 32'd0);
    check("t6_arst_empty", empty, 32'd1);
    check("t6_arst_dout", data_out, 32'h0);
    check("t6_arst_unf", underflow, 32'd0);
    check("t6_arst_ovf", overflow, 32'd0);
    cycle();
    reset = 1'b1;
    cycle();
    push_word(16'h0005);
    check("t6_count1", count, 32'd1);
    pop_word();
    check("t6_pop_5", data_out, 32'h0005);
    check("t6_count0", count, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
